// File: rtl/sniffer_pkg.sv
// Shared types and constants for the LPC/TPM sniffer datapath.
// Holds the drain sequencer state encoding and the frame header defaults.
package sniffer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP   = 3'd1,
        ST_LATCH = 3'd2,
        ST_SEND  = 3'd3,
        ST_GAP   = 3'd4,
        ST_WAIT  = 3'd5
    } state_t;

    localparam logic [7:0] SYNC_DEF     = 8'hA5;
    localparam logic [7:0] SYNC_OVF_DEF = 8'h5A;
    localparam int         DROP_CNT_W   = 16;

endpackage

// File: rtl/ringbuffer_drain.sv
// Pops one captured word from the ring buffer and streams it to the UART as a
// header byte followed by the word bytes MSB first; also counts dropped writes.
module ringbuffer_drain
    import sniffer_pkg::*;
#(
    parameter int         DW       = 32,
    parameter logic [7:0] SYNC     = SYNC_DEF,
    parameter logic [7:0] SYNC_OVF = SYNC_OVF_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  rb_empty,
    input  logic                  rb_overflow,
    input  logic                  rb_write_clk_enable,
    input  logic [DW-1:0]         rb_read_data,
    output logic                  rb_read_clk_enable,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    input  logic                  tx_busy,
    output logic                  busy,
    output logic [DROP_CNT_W-1:0] drop_count,
    output logic [2:0]            o_dbg_state
);

    localparam int             NB       = DW / 8;
    localparam int             IW       = $clog2(NB + 1);
    localparam logic [IW-1:0]  LAST_IDX = IW'(NB);

    state_t                  r_state;
    state_t                  w_next;
    logic [DW-1:0]           r_word;
    logic [IW-1:0]           r_idx;
    logic [7:0]              r_tx_data;
    logic                    r_drop;
    logic [DROP_CNT_W-1:0]   r_drop_cnt;
    logic                    w_drop;
    logic                    w_advance;
    logic [DW-1:0]           w_shifted;

    assign w_drop    = rb_write_clk_enable & rb_overflow;
    assign w_advance = (r_state == ST_WAIT) && !tx_busy && (r_idx != LAST_IDX);
    // Byte r_idx+1 of the frame sits at the top after shifting out r_idx bytes.
    assign w_shifted = r_word << (8 * r_idx);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // UART handshake: tx_start is a one-cycle strobe issued only after tx_busy
    // has been seen low; tx_busy rises the cycle after and GAP absorbs that lag.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (enable && !rb_empty && !tx_busy) w_next = ST_POP;
            ST_POP:   w_next = ST_LATCH;
            ST_LATCH: w_next = ST_SEND;
            ST_SEND:  w_next = ST_GAP;
            ST_GAP:   w_next = ST_WAIT;
            ST_WAIT: begin
                if (!tx_busy) begin
                    w_next = (r_idx == LAST_IDX) ? ST_IDLE : ST_SEND;
                end
            end
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_word    <= '0;
            r_idx     <= '0;
            r_tx_data <= 8'h00;
        end else if (r_state == ST_LATCH) begin
            r_word    <= rb_read_data;
            r_idx     <= '0;
            r_tx_data <= r_drop ? SYNC_OVF : SYNC;
        end else if (w_advance) begin
            r_idx     <= r_idx + 1'b1;
            r_tx_data <= w_shifted[DW-1 -: 8];
        end
    end

    // A drop landing on the LATCH cycle keeps the latch set for the next frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drop     <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_drop) begin
                r_drop <= 1'b1;
            end else if (r_state == ST_LATCH) begin
                r_drop <= 1'b0;
            end
            if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign rb_read_clk_enable = (r_state == ST_POP);
    assign tx_start           = (r_state == ST_SEND);
    assign busy               = (r_state != ST_IDLE);
    assign tx_data            = r_tx_data;
    assign drop_count         = r_drop_cnt;
    assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_ringbuffer_drain.sv
// Directed bench for ringbuffer_drain with a small ring buffer and UART model.
module tb_ringbuffer_drain;
    import sniffer_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          rb_empty;
    logic          rb_overflow;
    logic          wr = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] rb_read_data = '0;
    logic          rb_read_clk_enable;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_busy = 1'b0;
    logic          busy;
    logic [15:0]   drop_count;
    logic [2:0]    dbg_state;

    logic          ovf_force = 1'b0;
    logic          rb_flush = 1'b0;
    logic [DW-1:0] rb_q[$];
    int            rb_cnt = 0;
    logic [7:0]    exp_q[$];
    int            st_q[$];
    int            busy_len = 0;
    int            busy_rem = 0;
    int            cyc = 0;
    int            pop_cyc = 0;
    int            n_pops = 0;
    int            n_starts = 0;
    int            n_cmp = 0;
    int            n_err = 0;

    assign rb_empty    = (rb_cnt == 0);
    assign rb_overflow = (rb_cnt == DEPTH) | ovf_force;

    ringbuffer_drain #(.DW(DW)) dut (
        .clk                 (clk),
        .reset               (reset),
        .enable              (enable),
        .rb_empty            (rb_empty),
        .rb_overflow         (rb_overflow),
        .rb_write_clk_enable (wr),
        .rb_read_data        (rb_read_data),
        .rb_read_clk_enable  (rb_read_clk_enable),
        .tx_data             (tx_data),
        .tx_start            (tx_start),
        .tx_busy             (tx_busy),
        .busy                (busy),
        .drop_count          (drop_count),
        .o_dbg_state         (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- ring buffer model ----------------
    always @(posedge clk) begin
        if (rb_flush) begin
            rb_q.delete();
        end else begin
            if (rb_read_clk_enable && rb_q.size() > 0) rb_read_data <= rb_q.pop_front();
            if (wr && !rb_overflow) rb_q.push_back(wdata);
        end
        rb_cnt <= rb_q.size();
    end

    // ---------------- UART model + scoreboard ----------------
    always @(posedge clk) begin
        cyc++;
        if (rb_read_clk_enable) begin
            n_pops++;
            pop_cyc = cyc;
            check("pop_nonempty", 32'(rb_cnt != 0), 32'd1);
        end
        if (tx_start) begin
            n_starts++;
            st_q.push_back(cyc);
            check("start_while_busy", 32'(tx_busy), 32'd0);
            if (exp_q.size() > 0) check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
            else check("extra_start", 32'(exp_q.size()), 32'd1);
            if (busy_len > 0) begin
                busy_rem = busy_len;
                tx_busy <= 1'b1;
            end
        end else if (busy_rem > 0) begin
            busy_rem = busy_rem - 1;
            tx_busy <= (busy_rem > 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        rb_flush = 1'b1;
        repeat (2) @(negedge clk);
        rb_flush = 1'b0;
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic rb_write(input logic [DW-1:0] d);
        @(negedge clk);
        wr = 1'b1;
        wdata = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic push_frame(input logic [7:0] hdr, input logic [DW-1:0] w);
        exp_q.push_back(hdr);
        for (int k = 0; k < DW / 8; k++) exp_q.push_back(w[DW-1-8*k -: 8]);
    endtask

    task automatic wait_done(input string tag, input int max);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_starts(input int base, input int n, input int max);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (n_starts - base >= n) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_starts", 32'(ok), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int bp, bs;
        logic seen;

        apply_reset();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_pop", 32'(rb_read_clk_enable), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

        // single word, instantly idle UART
        busy_len = 0;
        bp = n_pops; bs = n_starts;
        st_q.delete();
        push_frame(8'hA5, 32'hDEADBEEF);
        enable = 1'b1;
        rb_write(32'hDEADBEEF);
        wait_done("single_done", 100);
        check("single_pops", 32'(n_pops - bp), 32'd1);
        check("single_starts", 32'(n_starts - bs), 32'd5);
        check("start_latency", 32'(st_q[0] - pop_cyc), 32'd2);
        check("byte_spacing", 32'(st_q[1] - st_q[0]), 32'd3);
        check("frame_span", 32'(st_q[4] - st_q[0]), 32'd12);

        // back-to-back words
        enable = 1'b0;
        bp = n_pops; bs = n_starts;
        push_frame(8'hA5, 32'h01020304);
        push_frame(8'hA5, 32'h0A0B0C0D);
        rb_write(32'h01020304);
        rb_write(32'h0A0B0C0D);
        enable = 1'b1;
        wait_done("b2b_done", 200);
        check("b2b_pops", 32'(n_pops - bp), 32'd2);
        check("b2b_starts", 32'(n_starts - bs), 32'd10);
        check("b2b_empty", 32'(rb_empty), 32'd1);

        // slow UART
        busy_len = 20;
        bs = n_starts;
        push_frame(8'hA5, 32'h11223344);
        rb_write(32'h11223344);
        wait_done("slow_done", 400);
        check("slow_starts", 32'(n_starts - bs), 32'd5);
        busy_len = 0;
        repeat (25) @(negedge clk);

        // overflow: three drops on a full buffer
        enable = 1'b0;
        apply_reset();
        rb_write(32'hA0B0C0D0);
        rb_write(32'h12345678);
        rb_write(32'h9ABCDEF0);
        rb_write(32'h0F1E2D3C);
        check("ovf_full", 32'(rb_overflow), 32'd1);
        rb_write(32'h77777777);
        rb_write(32'h77777777);
        rb_write(32'h77777777);
        check("ovf_drop_count", 32'(drop_count), 32'd3);
        push_frame(8'h5A, 32'hA0B0C0D0);
        push_frame(8'hA5, 32'h12345678);
        push_frame(8'hA5, 32'h9ABCDEF0);
        push_frame(8'hA5, 32'h0F1E2D3C);
        bp = n_pops;
        enable = 1'b1;
        wait_done("ovf_done", 400);
        check("ovf_pops", 32'(n_pops - bp), 32'd4);
        check("ovf_count_hold", 32'(drop_count), 32'd3);

        // drop coinciding with LATCH
        enable = 1'b0;
        apply_reset();
        rb_write(32'h600DF00D);
        rb_write(32'hCAFEF00D);
        push_frame(8'hA5, 32'h600DF00D);
        push_frame(8'h5A, 32'hCAFEF00D);
        enable = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rb_read_clk_enable) begin
                seen = 1'b1;
                break;
            end
        end
        check("coll_pop_seen", 32'(seen), 32'd1);
        @(negedge clk);
        check("coll_in_latch", 32'(dbg_state), 32'(ST_LATCH));
        wr = 1'b1;
        wdata = 32'hFFFFFFFF;
        ovf_force = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        ovf_force = 1'b0;
        wait_done("coll_done", 200);
        check("coll_drop_count", 32'(drop_count), 32'd1);

        // saturation
        enable = 1'b0;
        apply_reset();
        for (int i = 0; i < DEPTH; i++) rb_write(32'h5000_0000 + 32'(i));
        @(negedge clk);
        wr = 1'b1;
        repeat (65600) @(negedge clk);
        wr = 1'b0;
        check("sat_drop_count", 32'(drop_count), 32'h0000FFFF);

        // reset during byte 2
        apply_reset();
        busy_len = 5;
        bs = n_starts;
        push_frame(8'hA5, 32'h55667788);
        rb_write(32'h55667788);
        enable = 1'b1;
        wait_starts(bs, 3, 200);
        reset = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_tx_start", 32'(tx_start), 32'd0);
        check("midrst_tx_data", 32'(tx_data), 32'h00);
        check("midrst_pop", 32'(rb_read_clk_enable), 32'd0);
        check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        bp = n_pops; bs = n_starts;
        repeat (40) @(negedge clk);
        check("midrst_no_pop", 32'(n_pops - bp), 32'd0);
        check("midrst_no_start", 32'(n_starts - bs), 32'd0);
        busy_len = 0;

        // enable dropped mid-frame
        enable = 1'b0;
        apply_reset();
        rb_write(32'h13579BDF);
        rb_write(32'h2468ACE0);
        push_frame(8'hA5, 32'h13579BDF);
        bp = n_pops; bs = n_starts;
        enable = 1'b1;
        wait_starts(bs, 1, 50);
        enable = 1'b0;
        wait_done("en_done", 200);
        repeat (40) @(negedge clk);
        check("en_pops", 32'(n_pops - bp), 32'd1);
        check("en_starts", 32'(n_starts - bs), 32'd5);
        check("en_not_empty", 32'(rb_empty), 32'd0);
        check("en_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
